zet_intr_arb: RTL and testbench
===============================

ZET_INTR_ARB -- requirements
Module: zet_intr_arb

Interface
REQ-001 The block SHALL have these ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- irq  in  8  external interrupt lines; bit 0 highest priority.
- wr  in  1  register write strobe, one cycle per write.
- addr  in  1  register select: 0 = IMR, 1 = VBASE.
- wdata  in  8  write data.
- rdata  out  8  read data; addr 0 gives IMR, addr 1 gives ISR (combinational).
- eoi  in  1  non-specific end-of-interrupt pulse.
- intr  out  1  maskable request to decoder.
- inta  in  1  one-cycle acknowledge pulse from decoder.
- vector  out  8  interrupt vector number.
- nmi  in  1  NMI line; exists only with ZET_INTR_NMI_EN.
- nmir  out  1  NMI request to decoder.
- nmia  in  1  one-cycle NMI acknowledge from decoder.

Function
REQ-002 irq SHALL be registered once; a 0->1 transition of a sampled bit SHALL set the matching IRR bit on the next clock.
REQ-003 A level SHALL be pending when its IRR bit is 1 and its IMR bit is 0.
REQ-004 A pending level SHALL be eligible only if its index is lower than the lowest-index set ISR bit, or ISR is 0.
REQ-005 FSM states SHALL be IDLE, REQ and ACKD.
- IDLE to REQ when any level is eligible.
- REQ to ACKD on inta.
- ACKD to IDLE unconditionally after 1 cycle.
REQ-006 intr SHALL be 1 exactly while in REQ, so it asserts 1 cycle after eligibility is first seen.
REQ-007 On the inta cycle, the block SHALL select L, the lowest-index eligible level at that cycle; selection SHALL NOT be frozen at REQ entry.
REQ-008 On the inta edge, the block SHALL register vector = {VBASE[4:0], L[2:0]}, set ISR[L], clear IRR[L] and clear intr.
REQ-009 vector SHALL be held until the next inta.
REQ-010 If no level is eligible at inta (masked or withdrawn while in REQ), the response SHALL be spurious: vector = {VBASE, 3'd7}, and ISR and IRR unchanged.
REQ-011 If a new irq rising edge for level L and inta selecting L occur in the same cycle, IRR[L] SHALL remain set.
REQ-012 eoi SHALL clear the lowest-index set ISR bit; eoi with ISR = 0 SHALL have no effect.
REQ-013 If eoi and inta coincide, eoi SHALL act on ISR before the cycle's update, then ISR[L] SHALL be set.
REQ-014 A wr to addr 0 SHALL load IMR = wdata; a wr to addr 1 SHALL load VBASE = wdata[7:3]; both take effect on the next clock.
REQ-015 A mask change SHALL NOT clear IRR; unmasking a latched request SHALL make it pending.
REQ-016 While in REQ, inta SHALL be ignored in all other states, and a stray inta SHALL NOT change vector, ISR or IRR.

Reset
REQ-017 On rst low, the block SHALL asynchronously set:
- IMR = 8'hFF, VBASE = 5'h01, IRR = 0, ISR = 0.
- irq sample register = 0, vector = 8'h00, intr = 0, nmir = 0, FSM = IDLE.
REQ-018 A reset in REQ SHALL drop intr with no acknowledge side-effects.
REQ-019 An irq line high at reset release SHALL NOT count as an edge until it falls and rises again.

Configuration
REQ-020 With ZET_INTR_NMI_EN defined:
- A registered rising edge of nmi SHALL set nmir.
- nmia SHALL clear nmir.
- A simultaneous new nmi edge and nmia SHALL leave nmir set.
- NMI SHALL NOT affect IRR, ISR, intr or vector.
REQ-021 Without ZET_INTR_NMI_EN, the nmi port SHALL be absent, nmir SHALL be constant 0 and nmia SHALL be ignored.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Reset, write IMR = 8'hFE, pulse irq[0] -> intr=1 two cycles after the edge; inta -> vector=8'h08, ISR=8'h01, intr=0.
- irq[3] serviced (ISR=8'h08), then irq[5] edge -> no intr; irq[1] edge -> intr=1, inta -> vector=8'h09, ISR=8'h0A.
- intr high for irq[4], write IMR=8'hFF before inta, then inta -> vector=8'h0F, ISR unchanged, IRR[4]=1; IMR=0 -> intr re-asserts.
- ISR=8'h0A, eoi -> ISR=8'h08; eoi -> 0; eoi with ISR=0 -> no change.
- VBASE write wdata=8'h70, IMR=0, irq[2] edge, inta -> vector=8'h72.
- ZET_INTR_NMI_EN: nmi edge -> nmir=1 next cycle; nmia -> nmir=0; nmi edge coincident with nmia -> nmir stays 1. Without the macro: nmir=0 throughout.

Source files
------------

// File: rtl/zet_intr_arb_if.sv
// Bus bundle for zet_intr_arb: irq lines, register port, INTA/EOI handshake and NMI pair.
// The nmi line exists only when ZET_INTR_NMI_EN is defined.
interface zet_intr_arb_if;
  logic [7:0] irq;
  logic       wr;
  logic       addr;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       eoi;
  logic       intr;
  logic       inta;
  logic [7:0] vector;
`ifdef ZET_INTR_NMI_EN
  logic       nmi;
`endif
  logic       nmir;
  logic       nmia;

`ifdef ZET_INTR_NMI_EN
  modport master (
    output irq, wr, addr, wdata, eoi, inta, nmi, nmia,
    input  rdata, intr, vector, nmir
  );
  modport slave (
    input  irq, wr, addr, wdata, eoi, inta, nmi, nmia,
    output rdata, intr, vector, nmir
  );
`else
  modport master (
    output irq, wr, addr, wdata, eoi, inta, nmia,
    input  rdata, intr, vector, nmir
  );
  modport slave (
    input  irq, wr, addr, wdata, eoi, inta, nmia,
    output rdata, intr, vector, nmir
  );
`endif
endinterface

// File: rtl/zet_intr_arb.sv
// 8-level fixed-priority interrupt arbiter with IMR/IRR/ISR, INTA vector handshake and EOI.
// Define ZET_INTR_NMI_EN to add the edge-triggered nmi input feeding nmir.
module zet_intr_arb (
  input  logic           clk,
  input  logic           rst,
  zet_intr_arb_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StReq, StAckd} state_e;

  state_e     state_q, state_d;
  logic [7:0] imr_q, imr_d;
  logic [4:0] vbase_q, vbase_d;
  logic [7:0] irr_q, irr_d;
  logic [7:0] isr_q, isr_d;
  logic [7:0] vector_q, vector_d;
  logic [7:0] irq_q;
  logic       arm_q;

  logic [7:0] rise;
  logic [7:0] isr_low;
  logic [7:0] prio_mask;
  logic [7:0] eligible;
  logic       any_elig;
  logic       ack;
  logic [2:0] sel;

  // arm_q blocks the first post-reset clock so a line already high is not seen as an edge.
  assign rise      = arm_q ? (bus.irq & ~irq_q) : 8'h00;
  assign isr_low   = isr_q & (~isr_q + 8'd1);
  // All bits below the highest-priority in-service level; all ones when ISR is empty.
  assign prio_mask = isr_low - 8'd1;
  assign eligible  = irr_q & ~imr_q & prio_mask;
  assign any_elig  = |eligible;
  assign ack       = (state_q == StReq) && bus.inta;

  always_comb begin
    sel = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (eligible[i]) sel = 3'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (any_elig) state_d = StReq;
      StReq:   if (bus.inta) state_d = StAckd;
      StAckd:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    imr_d    = imr_q;
    vbase_d  = vbase_q;
    irr_d    = irr_q;
    vector_d = vector_q;
    isr_d    = bus.eoi ? (isr_q & ~isr_low) : isr_q;

    if (bus.wr) begin
      if (bus.addr) vbase_d = bus.wdata[7:3];
      else          imr_d   = bus.wdata;
    end

    if (ack) begin
      if (any_elig) begin
        isr_d[sel] = 1'b1;
        irr_d[sel] = 1'b0;
        vector_d   = {vbase_q, sel};
      end else begin
        vector_d   = {vbase_q, 3'd7};
      end
    end

    // A fresh edge on the acknowledged level re-latches it.
    irr_d = irr_d | rise;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      imr_q    <= 8'hFF;
      vbase_q  <= 5'h01;
      irr_q    <= 8'h00;
      isr_q    <= 8'h00;
      vector_q <= 8'h00;
      irq_q    <= 8'h00;
      arm_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      imr_q    <= imr_d;
      vbase_q  <= vbase_d;
      irr_q    <= irr_d;
      isr_q    <= isr_d;
      vector_q <= vector_d;
      irq_q    <= bus.irq;
      arm_q    <= 1'b1;
    end
  end

  assign bus.intr   = (state_q == StReq);
  assign bus.vector = vector_q;
  assign bus.rdata  = bus.addr ? isr_q : imr_q;

`ifdef ZET_INTR_NMI_EN
  logic nmi_q;
  logic nmir_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      nmi_q  <= 1'b0;
      nmir_q <= 1'b0;
    end else begin
      nmi_q  <= bus.nmi;
      nmir_q <= (nmir_q & ~bus.nmia) | (arm_q & bus.nmi & ~nmi_q);
    end
  end

  assign bus.nmir = nmir_q;
`else
  logic unused_nmia;
  assign unused_nmia = bus.nmia;
  assign bus.nmir    = 1'b0;
`endif

endmodule

// File: tb/tb_zet_intr_arb.sv
// Directed bench for zet_intr_arb: expected values queued as stimulus is applied, popped on check.
// Covers the NMI path when ZET_INTR_NMI_EN is defined.
module tb_zet_intr_arb;

  logic clk = 1'b0;
  logic rst;

  zet_intr_arb_if bus ();

  zet_intr_arb u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;
  string       tag_q[$];
  logic [7:0]  exp_q[$];

  task automatic expect_val(input string tag, input logic [7:0] val);
    tag_q.push_back(tag);
    exp_q.push_back(val);
  endtask

  task automatic check_val(input logic [7:0] obs);
    string      tag;
    logic [7:0] exp;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $error("FAIL scoreboard_empty: observed %h, nothing expected", obs);
    end else begin
      tag = tag_q.pop_front();
      exp = exp_q.pop_front();
      assert (obs === exp) else begin
        miscompares++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_intr(input string tag, input logic v);
    expect_val(tag, {7'b0, v});
    check_val({7'b0, bus.intr});
  endtask

  task automatic chk_vec(input string tag, input logic [7:0] v);
    expect_val(tag, v);
    check_val(bus.vector);
  endtask

  task automatic chk_nmir(input string tag, input logic v);
    expect_val(tag, {7'b0, v});
    check_val({7'b0, bus.nmir});
  endtask

  task automatic chk_isr(input string tag, input logic [7:0] v);
    expect_val(tag, v);
    bus.addr = 1'b1;
    #1;
    check_val(bus.rdata);
  endtask

  task automatic chk_imr(input string tag, input logic [7:0] v);
    expect_val(tag, v);
    bus.addr = 1'b0;
    #1;
    check_val(bus.rdata);
    bus.addr = 1'b1;
  endtask

  task automatic wr_reg(input logic a, input logic [7:0] d);
    bus.wr = 1'b1; bus.addr = a; bus.wdata = d;
    cyc(1);
    bus.wr = 1'b0; bus.addr = 1'b1;
  endtask

  task automatic pulse_irq(input int i);
    bus.irq[i] = 1'b1;
    cyc(1);
    bus.irq[i] = 1'b0;
  endtask

  task automatic ack();
    bus.inta = 1'b1;
    cyc(1);
    bus.inta = 1'b0;
  endtask

  task automatic eoi_pulse();
    bus.eoi = 1'b1;
    cyc(1);
    bus.eoi = 1'b0;
  endtask

  initial begin
    rst       = 1'b0;
    bus.irq   = 8'h00;
    bus.wr    = 1'b0;
    bus.addr  = 1'b1;
    bus.wdata = 8'h00;
    bus.eoi   = 1'b0;
    bus.inta  = 1'b0;
    bus.nmia  = 1'b0;
`ifdef ZET_INTR_NMI_EN
    bus.nmi   = 1'b0;
`endif
    cyc(2);
    chk_intr("rst_intr", 1'b0);
    chk_vec("rst_vector", 8'h00);
    chk_nmir("rst_nmir", 1'b0);
    chk_isr("rst_isr", 8'h00);
    chk_imr("rst_imr", 8'hFF);
    rst = 1'b1;
    cyc(2);

    // irq[0] through IMR=FE, base vector 0x08
    wr_reg(1'b0, 8'hFE);
    chk_imr("imr_fe", 8'hFE);
    pulse_irq(0);
    chk_intr("irq0_intr_early", 1'b0);
    cyc(1);
    chk_intr("irq0_intr", 1'b1);
    ack();
    chk_vec("irq0_vector", 8'h08);
    chk_intr("irq0_intr_ack", 1'b0);
    chk_isr("irq0_isr", 8'h01);
    ack();
    ack();
    chk_vec("stray_vector", 8'h08);
    chk_isr("stray_isr", 8'h01);
    eoi_pulse();
    chk_isr("eoi_isr0", 8'h00);

    // Nesting: irq[5] blocked by ISR[3], irq[1] preempts
    wr_reg(1'b0, 8'h00);
    pulse_irq(3);
    cyc(1);
    chk_intr("irq3_intr", 1'b1);
    ack();
    chk_vec("irq3_vector", 8'h0B);
    chk_isr("irq3_isr", 8'h08);
    pulse_irq(5);
    cyc(3);
    chk_intr("irq5_blocked", 1'b0);
    pulse_irq(1);
    cyc(1);
    chk_intr("irq1_intr", 1'b1);
    ack();
    chk_vec("irq1_vector", 8'h09);
    chk_isr("irq1_isr", 8'h0A);

    // EOI walks ISR from the highest-priority bit; latched irq[5] then surfaces
    eoi_pulse();
    chk_isr("eoi_isr_08", 8'h08);
    chk_intr("irq5_still_blocked", 1'b0);
    eoi_pulse();
    chk_isr("eoi_isr_00", 8'h00);
    eoi_pulse();
    chk_isr("eoi_empty", 8'h00);
    chk_intr("irq5_intr", 1'b1);
    ack();
    chk_vec("irq5_vector", 8'h0D);
    chk_isr("irq5_isr", 8'h20);
    eoi_pulse();

    // Masked before INTA -> spurious; unmask re-raises the latched request
    pulse_irq(4);
    cyc(1);
    chk_intr("irq4_intr", 1'b1);
    wr_reg(1'b0, 8'hFF);
    ack();
    chk_vec("spurious_vector", 8'h0F);
    chk_intr("spurious_intr", 1'b0);
    chk_isr("spurious_isr", 8'h00);
    cyc(3);
    chk_intr("irq4_masked", 1'b0);
    wr_reg(1'b0, 8'h00);
    cyc(1);
    chk_intr("irq4_unmasked", 1'b1);
    ack();
    chk_vec("irq4_vector", 8'h0C);
    chk_isr("irq4_isr", 8'h10);
    eoi_pulse();

    // VBASE = 0x70 >> 3
    wr_reg(1'b1, 8'h70);
    pulse_irq(2);
    cyc(1);
    chk_intr("irq2_intr", 1'b1);
    ack();
    chk_vec("vbase_vector", 8'h72);
    chk_isr("irq2_isr", 8'h04);

    // EOI coincident with INTA
    pulse_irq(1);
    cyc(1);
    chk_intr("irq1b_intr", 1'b1);
    bus.inta = 1'b1;
    bus.eoi  = 1'b1;
    cyc(1);
    bus.inta = 1'b0;
    bus.eoi  = 1'b0;
    chk_vec("eoi_inta_vector", 8'h71);
    chk_isr("eoi_inta_isr", 8'h02);
    eoi_pulse();
    chk_isr("eoi_inta_clear", 8'h00);

    // New irq[6] edge on its own INTA cycle keeps IRR[6]
    pulse_irq(6);
    cyc(1);
    chk_intr("irq6_intr", 1'b1);
    bus.irq[6] = 1'b1;
    bus.inta   = 1'b1;
    cyc(1);
    bus.inta   = 1'b0;
    bus.irq[6] = 1'b0;
    chk_vec("irq6_vector", 8'h76);
    chk_isr("irq6_isr", 8'h40);
    cyc(2);
    chk_intr("irq6_blocked", 1'b0);
    eoi_pulse();
    cyc(1);
    chk_intr("irq6_relatched", 1'b1);
    ack();
    chk_vec("irq6_vector2", 8'h76);
    eoi_pulse();

`ifdef ZET_INTR_NMI_EN
    bus.nmi = 1'b1;
    cyc(1);
    chk_nmir("nmi_set", 1'b1);
    cyc(2);
    chk_nmir("nmi_hold", 1'b1);
    bus.nmia = 1'b1;
    cyc(1);
    bus.nmia = 1'b0;
    chk_nmir("nmia_clear", 1'b0);
    bus.nmi = 1'b0;
    cyc(1);
    bus.nmi = 1'b1;
    cyc(1);
    chk_nmir("nmi_set2", 1'b1);
    bus.nmi = 1'b0;
    cyc(1);
    bus.nmi  = 1'b1;
    bus.nmia = 1'b1;
    cyc(1);
    bus.nmia = 1'b0;
    chk_nmir("nmi_nmia_same", 1'b1);
    chk_intr("nmi_no_intr", 1'b0);
    chk_vec("nmi_no_vector", 8'h76);
    bus.nmia = 1'b1;
    cyc(1);
    bus.nmia = 1'b0;
    bus.nmi  = 1'b0;
    chk_nmir("nmia_clear2", 1'b0);
`else
    bus.nmia = 1'b1;
    cyc(2);
    chk_nmir("nmir_tied_a", 1'b0);
    bus.nmia = 1'b0;
    cyc(1);
    chk_nmir("nmir_tied_b", 1'b0);
`endif

    // Reset while requesting, then a line held high across release
    pulse_irq(7);
    cyc(1);
    chk_intr("irq7_intr", 1'b1);
    rst = 1'b0;
    #1;
    chk_intr("rst_req_intr", 1'b0);
    chk_vec("rst_req_vector", 8'h00);
    chk_imr("rst_req_imr", 8'hFF);
    bus.irq[7] = 1'b1;
    cyc(1);
    rst = 1'b1;
    cyc(1);
    wr_reg(1'b0, 8'h00);
    cyc(3);
    chk_intr("held_irq_no_edge", 1'b0);
    bus.irq[7] = 1'b0;
    cyc(1);
    pulse_irq(7);
    cyc(1);
    chk_intr("irq7_new_edge", 1'b1);
    ack();
    chk_vec("irq7_vector", 8'h0F);
    chk_isr("irq7_isr", 8'h80);
    chk_nmir("final_nmir", 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
